// File: rtl/button_pulser_if.sv
// Front-panel button bundle: raw buttons and repeat enable in, conditioned
// counter pulses and debug levels/FSM states out.
// Pulse contract: inc/dec are one-cycle strobes with no back-pressure; the
// counter must consume every cycle in which one is high.
interface button_pulser_if;
  logic       btn_up;
  logic       btn_down;
  logic       repeat_en;
  logic       inc;
  logic       dec;
  logic       up_level;
  logic       down_level;
  logic [1:0] up_state;
  logic [1:0] down_state;

  modport master (
    output btn_up, btn_down, repeat_en,
    input  inc, dec, up_level, down_level, up_state, down_state
  );

  modport slave (
    input  btn_up, btn_down, repeat_en,
    output inc, dec, up_level, down_level, up_state, down_state
  );
endinterface

// File: rtl/button_pulser.sv
// Button conditioner: per button a 2-flop synchronizer, a debounce filter and
// a press / hold-to-repeat FSM. Channel 0 drives inc, channel 1 drives dec.
// Pulses are dropped (not deferred) while both filtered levels are high.
module button_pulser #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
) (
  input  logic           clk,
  input  logic           rst,
  button_pulser_if.slave bus
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX);

  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [1:0] raw_w;
  logic [1:0] filt_d_all;
  logic [1:0] filt_q_all;
  logic [1:0] pulse_all;
  logic [1:0] state_all [2];
  logic       both_high_d;

  assign raw_w       = {bus.btn_down, bus.btn_up};
  // Exclusion is judged on the levels that will be visible with the pulse.
  assign both_high_d = &filt_d_all;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          filt_q;
    logic          filt_d;
    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic          pulse_q;

    // Synchronize the raw button and register the debounce filter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= '0;
        filt_q  <= 1'b0;
      end else begin
        sync1_q <= raw_w[ch];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        filt_q  <= filt_d;
      end
    end

    // Accept a level change only after it has persisted DEBOUNCE_CYCLES cycles.
    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync2_q != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // Press / hold / repeat FSM; it reacts to the next filtered level so the
    // press pulse appears together with the filtered rise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_IDLE;
        timer_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (!filt_d) begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              state_q <= ST_HOLD;
              timer_q <= DELAY_LOAD;
              pulse_q <= !both_high_d;
            end
            ST_HOLD: begin
              if (!bus.repeat_en) begin
                timer_q <= '0;
              end else if (timer_q != TIMER_ZERO) begin
                timer_q <= timer_q - TW'(1);
              end else begin
                state_q <= ST_REPEAT;
                timer_q <= PERIOD_LOAD;
                pulse_q <= !both_high_d;
              end
            end
            ST_REPEAT: begin
              if (!bus.repeat_en) begin
                state_q <= ST_HOLD;
                timer_q <= '0;
              end else if (timer_q != TIMER_ZERO) begin
                timer_q <= timer_q - TW'(1);
              end else begin
                timer_q <= PERIOD_LOAD;
                pulse_q <= !both_high_d;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end
          endcase
        end
      end
    end

    assign filt_d_all[ch] = filt_d;
    assign filt_q_all[ch] = filt_q;
    assign pulse_all[ch]  = pulse_q;
    assign state_all[ch]  = state_q;
  end

  assign bus.inc        = pulse_all[0];
  assign bus.dec        = pulse_all[1];
  assign bus.up_level   = filt_q_all[0];
  assign bus.down_level = filt_q_all[1];
  assign bus.up_state   = state_all[0];
  assign bus.down_state = state_all[1];

endmodule

// File: tb/tb_button_pulser.sv
// Directed bench for button_pulser: each stimulus step pushes the expected
// pulse (cycle stamp + direction) into exp_q, and a negedge monitor pops and
// compares whenever inc or dec is high.
module tb_button_pulser;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_got;
  logic [31:0] mon_want;
  int unsigned base;

  button_pulser_if bif ();

  button_pulser dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Clock and free-running cycle stamp (edge k after a negedge drive at
  // stamp B is stamped B+k).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.inc && bif.dec) begin
        total++;
        bad++;
        $display("FAIL excl: inc and dec both high at cyc=%0d, required at most one", cyc);
      end
      if (bif.inc || bif.dec) begin
        total++;
        mon_got = {cyc[30:0], bif.dec};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pulse: got cyc=%0d dec=%0b, required no pulse", cyc, bif.dec);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got !== mon_want) begin
            bad++;
            $display("FAIL pulse: got cyc=%0d dec=%0b, required cyc=%0d dec=%0b",
                     mon_got[31:1], mon_got[0], mon_want[31:1], mon_want[0]);
          end
        end
      end
    end
  end

  task automatic goto_edge(input int unsigned b, input int k);
    while (cyc < b + k) @(negedge clk);
  endtask

  task automatic expect_pulse(input int unsigned at, input bit is_dec);
    exp_q.push_back({at[30:0], is_dec});
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0b, required %0b (cyc=%0d)", name, got, req, cyc);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected pulses never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Watchdog so the run always ends with a summary.
  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog: time limit reached, required test completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst           = 1'b1;
    bif.btn_up    = 1'b0;
    bif.btn_down  = 1'b0;
    bif.repeat_en = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("rst_inc", bif.inc, 1'b0);
    check_bit("rst_dec", bif.dec, 1'b0);
    check_bit("rst_up_level", bif.up_level, 1'b0);
    check_bit("rst_down_level", bif.down_level, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single press, no repeat, release
    base = cyc;
    bif.btn_up = 1'b1;
    expect_pulse(base + 6, 1'b0);
    goto_edge(base, 5);
    check_bit("t1_level_e5", bif.up_level, 1'b0);
    goto_edge(base, 6);
    check_bit("t1_level_e6", bif.up_level, 1'b1);
    goto_edge(base, 10);
    bif.btn_up = 1'b0;
    goto_edge(base, 15);
    check_bit("t1_level_e15", bif.up_level, 1'b1);
    goto_edge(base, 16);
    check_bit("t1_level_e16", bif.up_level, 1'b0);
    goto_edge(base, 30);
    check_drained("t1_drained");

    // 2: bounce shorter than the debounce window
    base = cyc;
    bif.btn_up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      goto_edge(base, k);
      check_bit("t2_bounce_level", bif.up_level, 1'b0);
      if (k == 3) bif.btn_up = 1'b0;
      if (k == 5) bif.btn_up = 1'b1;
      if (k == 8) bif.btn_up = 1'b0;
    end
    check_drained("t2_drained");

    // 3: hold-to-repeat
    bif.repeat_en = 1'b1;
    base = cyc;
    bif.btn_up = 1'b1;
    expect_pulse(base + 6, 1'b0);
    expect_pulse(base + 14, 1'b0);
    expect_pulse(base + 17, 1'b0);
    expect_pulse(base + 20, 1'b0);
    expect_pulse(base + 23, 1'b0);
    goto_edge(base, 20);
    bif.btn_up = 1'b0;
    goto_edge(base, 25);
    check_bit("t3_level_e25", bif.up_level, 1'b1);
    goto_edge(base, 26);
    check_bit("t3_level_e26", bif.up_level, 1'b0);
    goto_edge(base, 40);
    check_drained("t3_drained");

    // 4: overlap of both buttons, up repeats resume after down releases
    base = cyc;
    bif.btn_down = 1'b1;
    expect_pulse(base + 6, 1'b1);
    expect_pulse(base + 19, 1'b0);
    expect_pulse(base + 22, 1'b0);
    expect_pulse(base + 25, 1'b0);
    expect_pulse(base + 28, 1'b0);
    goto_edge(base, 2);
    bif.btn_up = 1'b1;
    goto_edge(base, 10);
    check_bit("t4_up_level_both", bif.up_level, 1'b1);
    check_bit("t4_down_level_both", bif.down_level, 1'b1);
    goto_edge(base, 11);
    bif.btn_down = 1'b0;
    goto_edge(base, 17);
    check_bit("t4_down_level_e17", bif.down_level, 1'b0);
    goto_edge(base, 23);
    bif.btn_up = 1'b0;
    goto_edge(base, 40);
    check_drained("t4_drained");
    bif.repeat_en = 1'b0;

    // 5: reset while held, fresh press after release of reset
    base = cyc;
    bif.btn_up = 1'b1;
    expect_pulse(base + 6, 1'b0);
    goto_edge(base, 9);
    rst = 1'b1;
    #1;
    check_bit("t5_rst_level_now", bif.up_level, 1'b0);
    check_bit("t5_rst_inc_now", bif.inc, 1'b0);
    repeat (2) @(negedge clk);
    check_bit("t5_rst_level_held", bif.up_level, 1'b0);
    rst = 1'b0;
    base = cyc;
    expect_pulse(base + 6, 1'b0);
    goto_edge(base, 5);
    check_bit("t5_level_e5", bif.up_level, 1'b0);
    goto_edge(base, 6);
    check_bit("t5_level_e6", bif.up_level, 1'b1);
    goto_edge(base, 10);
    bif.btn_up = 1'b0;
    goto_edge(base, 25);
    check_drained("t5_drained");

    // 6: long hold without repeat, then enable and later disable repeat
    base = cyc;
    bif.btn_down = 1'b1;
    expect_pulse(base + 6, 1'b1);
    expect_pulse(base + 21, 1'b1);
    expect_pulse(base + 24, 1'b1);
    expect_pulse(base + 27, 1'b1);
    expect_pulse(base + 30, 1'b1);
    goto_edge(base, 20);
    bif.repeat_en = 1'b1;
    goto_edge(base, 30);
    bif.repeat_en = 1'b0;
    goto_edge(base, 40);
    bif.btn_down = 1'b0;
    goto_edge(base, 45);
    check_bit("t6_level_e45", bif.down_level, 1'b1);
    goto_edge(base, 46);
    check_bit("t6_level_e46", bif.down_level, 1'b0);
    goto_edge(base, 55);
    check_drained("t6_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_pulser.md
Name: button_pulser

Overview:
Conditions the two raw front-panel buttons (up, down) into clean single-cycle inc/dec pulses for the modulo up/down counter stage directly downstream. Each button is synchronized, debounced and edge-detected. An optional hold-to-repeat mode generates additional pulses while a button stays held. The two outputs are never high in the same cycle.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a level change (>=1)
REPEAT_DELAY, 8, cycles from the first press pulse to the first repeat pulse (>=2)
REPEAT_PERIOD, 3, cycles between subsequent repeat pulses (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
btn_up  input  1  raw, asynchronous up button (active high)
btn_down  input  1  raw, asynchronous down button (active high)
repeat_en  input  1  synchronous; 1 enables hold-to-repeat
inc  output  1  one-cycle increment pulse to the counter
dec  output  1  one-cycle decrement pulse to the counter
up_level  output  1  debounced up level (debug)
down_level  output  1  debounced down level (debug)

Behaviour:
- Reset (async, active-high): all synchronizer flops, debounce counters, filtered levels, state and timers go to 0. Outputs inc, dec, up_level and down_level are 0 immediately and stay 0 while rst=1.
- Identical per-button channel.
- Synchronizer: 2 flops. Edge numbering: the first clock edge that samples raw high is edge 1. The synchronized level is high after edge 2.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES+1):
  - Cleared whenever the synchronized level equals the filtered level.
  - Otherwise it increments.
  - When it equals DEBOUNCE_CYCLES-1 and the levels still differ, the filtered level takes the synchronized level at that edge and the counter clears.
  - Result: a clean press sets the filtered level at edge DEBOUNCE_CYCLES+2. A release clears it at the same latency after raw falls.
  - A bounce shorter than DEBOUNCE_CYCLES synchronized cycles never changes the filtered level.
- Per-channel FSM:
  - IDLE: waits for the filtered level to rise.
  - On the rise, the press pulse is issued in the cycle after the edge that set the filtered level. The FSM then enters HOLD and loads the timer with REPEAT_DELAY-1.
  - HOLD: the timer decrements each cycle. At 0, if repeat_en=1 and the filtered level is high, a repeat pulse is issued, the timer reloads REPEAT_PERIOD-1 and the FSM goes to REPEAT.
  - HOLD with repeat_en=0: the FSM stays in HOLD and the timer is held at 0 with no pulses.
  - REPEAT: a pulse is issued each time the timer reaches 0, then the timer reloads REPEAT_PERIOD-1.
  - Filtered level low in any state: return to IDLE and clear the timer. No pulse is issued on release or in that cycle.
  - repeat_en deasserted in REPEAT: go to HOLD with the timer at 0. No further pulses.
- Pulses are registered. Each pulse is high for exactly 1 cycle, and the next pulse comes at least 2 cycles later.
- Mutual exclusion: while both filtered levels are high, inc=dec=0. Both FSMs and timers keep running and their pulses are dropped, not deferred.
- Reset mid-hold: outputs drop at once. After rst releases with a button still held, the sequence restarts from IDLE: a fresh press pulse follows at the standard latency.
- Timer width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). The timer does not wrap; it saturates at 0.

Test Plan:
(Defaults D=4, RD=8, RP=3; edges counted from the first edge sampling raw high.)
1. btn_up high for edges 1-10, then low -> inc=1 only in the cycle after edge 6; dec=0 throughout; no pulse on release; up_level falls at edge 16.
2. btn_up high for 3 cycles, low for 2, high for 3 (bounce) -> inc never asserts; up_level stays 0.
3. repeat_en=1, btn_up high for edges 1-20 -> inc pulses exactly after edges 6, 14, 17, 20 and 23 (5 pulses); none after up_level falls at edge 26.
4. btn_down pressed alone, then btn_up pressed while down is still held -> one dec pulse after edge 6; no inc or dec while both levels are high; after btn_down releases, up-channel repeat pulses resume on their original timer schedule.
5. Hold btn_up and assert rst at edge 10 for 2 cycles, button still held -> inc=0 immediately; after release, inc pulses 6 edges after the first post-reset sampling edge.
6. repeat_en=0, btn_down held for 40 cycles -> exactly one dec pulse (after edge 6); then set repeat_en=1 mid-hold -> next dec on the following cycle's timer-0 check, then every 3 cycles.
